// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: state encoding, opcode width
// and the board-default debounce length.
package alu_operand_loader_pkg;

    localparam int OP_W                    = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // One-hot so the state register can drive the stage LEDs directly.
    typedef enum logic [4:0] {
        ST_A    = 5'b00001,
        ST_B    = 5'b00010,
        ST_OP   = 5'b00100,
        ST_EXEC = 5'b01000,
        ST_DONE = 5'b10000
    } state_e;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-run counter and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import alu_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; flip the level after a full run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = {CNT_W{1'b0}};
                level_d = ~level_q;
                // Only the rising transition is a press; releases stay silent.
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        level = level_q;
        press = press_q;
    end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand entry front end: debounces the next/clear buttons, steps
// A -> B -> OP -> EXEC -> DONE capturing synchronised switch values, and
// issues a one-cycle ALU enable with the operands already stable.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_next,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_enable,
    output logic              result_ready,
    output logic [4:0]        stage
);

    logic [DATA_W-1:0] sw_sync1_q;
    logic [DATA_W-1:0] sw_sync2_q;
    logic              next_press_s;
    logic              clear_press_s;
    logic              unused_next_level_s;
    logic              unused_clear_level_s;
    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] b_d;
    logic [OP_W-1:0]   op_q;
    logic [OP_W-1:0]   op_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_next),
        .level   (unused_next_level_s),
        .press   (next_press_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_clear),
        .level   (unused_clear_level_s),
        .press   (clear_press_s)
    );

    // Two-flop synchroniser for the quasi-static switch bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync1_q <= {DATA_W{1'b0}};
            sw_sync2_q <= {DATA_W{1'b0}};
        end else begin
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides any simultaneous next press.
    always_comb begin
        state_d = state_q;
        if (clear_press_s) begin
            state_d = ST_A;
        end else begin
            case (state_q)
                ST_A:    state_d = next_press_s ? ST_B    : ST_A;
                ST_B:    state_d = next_press_s ? ST_OP   : ST_B;
                ST_OP:   state_d = next_press_s ? ST_EXEC : ST_OP;
                // EXEC is a single cycle; a press arriving here is ignored.
                ST_EXEC: state_d = ST_DONE;
                ST_DONE: state_d = next_press_s ? ST_A    : ST_DONE;
                default: state_d = ST_A;
            endcase
        end
    end

    // Capture logic: each operand register loads only on its own step.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (clear_press_s) begin
            a_d  = {DATA_W{1'b0}};
            b_d  = {DATA_W{1'b0}};
            op_d = {OP_W{1'b0}};
        end else if (next_press_s) begin
            case (state_q)
                ST_A:    a_d  = sw_sync2_q;
                ST_B:    b_d  = sw_sync2_q;
                ST_OP:   op_d = sw_sync2_q[OP_W-1:0];
                default: a_d  = a_q;
            endcase
        end else begin
            a_d = a_q;
        end
    end

    // Operand and opcode registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= {DATA_W{1'b0}};
            b_q  <= {DATA_W{1'b0}};
            op_q <= {OP_W{1'b0}};
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        alu_a        = a_q;
        alu_b        = b_q;
        alu_op       = op_q;
        alu_enable   = (state_q == ST_EXEC);
        result_ready = (state_q == ST_DONE);
        stage        = state_q;
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a short debounce length.
module tb_alu_operand_loader;

    localparam int DW = 16;
    localparam int DC = 4;
    localparam logic [42:0] RST_VEC = {16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 5'b00001};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] sw;
    logic          btn_next;
    logic          btn_clear;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic          alu_enable;
    logic          result_ready;
    logic [4:0]    stage;
    logic [42:0]   dut_vec;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .DATA_W          (DW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw           (sw),
        .btn_next     (btn_next),
        .btn_clear    (btn_clear),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_enable   (alu_enable),
        .result_ready (result_ready),
        .stage        (stage)
    );

    assign dut_vec = {alu_a, alu_b, alu_op, alu_enable, result_ready, stage};

    // Reference model: a button is accepted once its last DC synchronised
    // samples all disagree with the accepted level; sequence kept as a step index.
    logic [DW-1:0] m_sw1, m_sw2, m_a, m_b;
    logic [3:0]    m_op;
    logic          m_n1, m_n2, m_c1, m_c2, m_nl, m_cl, m_np, m_cp;
    logic [DC-1:0] m_nh, m_ch;
    int            m_idx;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sw1 <= '0; m_sw2 <= '0; m_a <= '0; m_b <= '0; m_op <= '0;
            m_n1 <= 1'b0; m_n2 <= 1'b0; m_c1 <= 1'b0; m_c2 <= 1'b0;
            m_nl <= 1'b0; m_cl <= 1'b0; m_np <= 1'b0; m_cp <= 1'b0;
            m_nh <= '0; m_ch <= '0; m_idx <= 0;
        end else begin
            m_sw1 <= sw;        m_sw2 <= m_sw1;
            m_n1  <= btn_next;  m_n2  <= m_n1;
            m_c1  <= btn_clear; m_c2  <= m_c1;
            m_nh  <= {m_nh[DC-2:0], m_n2};
            m_ch  <= {m_ch[DC-2:0], m_c2};
            if ({m_nh[DC-2:0], m_n2} == {DC{~m_nl}}) begin
                m_nl <= ~m_nl; m_np <= ~m_nl;
            end else begin
                m_np <= 1'b0;
            end
            if ({m_ch[DC-2:0], m_c2} == {DC{~m_cl}}) begin
                m_cl <= ~m_cl; m_cp <= ~m_cl;
            end else begin
                m_cp <= 1'b0;
            end
            if (m_cp) begin
                m_idx <= 0; m_a <= '0; m_b <= '0; m_op <= '0;
            end else if (m_idx == 3) begin
                m_idx <= 4;
            end else if (m_np) begin
                case (m_idx)
                    0: begin m_a  <= m_sw2;      m_idx <= 1; end
                    1: begin m_b  <= m_sw2;      m_idx <= 2; end
                    2: begin m_op <= m_sw2[3:0]; m_idx <= 3; end
                    4: m_idx <= 0;
                    default: m_idx <= 0;
                endcase
            end
        end
    end

    function automatic logic [42:0] exp_vec();
        return {m_a, m_b, m_op, (m_idx == 3), (m_idx == 4), 5'(1 << m_idx)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus helper: settle sw, hold buttons, release, count enable cycles.
    task automatic do_press(input logic nx, input logic cl, input logic [DW-1:0] v,
                            input int hold, output int en_cnt);
        en_cnt = 0;
        sw = v;
        cyc(3);
        btn_next = nx;
        btn_clear = cl;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (alu_enable) en_cnt++;
            if (k == DC + 3) sw = 16'($urandom);
        end
        btn_next = 1'b0;
        btn_clear = 1'b0;
        for (int k = 0; k < DC + 4; k++) begin
            @(negedge clk);
            if (alu_enable) en_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sw = 16'($urandom); btn_next = 1'($urandom); btn_clear = 1'($urandom);
            total++;
            if (dut_vec !== RST_VEC) begin
                bad++; $display("FAIL reset_hold got=%h want=%h", dut_vec, RST_VEC);
            end
        end
        btn_next = 1'b0; btn_clear = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== RST_VEC) begin
                bad++; $display("FAIL reset_release got=%h want=%h", dut_vec, RST_VEC);
            end
        end
    endtask

    task automatic test_glitch_capture();
        sw = 16'hAAAA;
        cyc(3);
        btn_next = 1'b1;
        cyc(3);
        btn_next = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (stage !== 5'b00001 || alu_a !== 16'h0000) begin
                bad++; $display("FAIL glitch stage=%b a=%h want stage=00001 a=0000", stage, alu_a);
            end
        end
        btn_next = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) begin
                total++;
                if (alu_a !== 16'h0000 || stage !== 5'b00001) begin
                    bad++; $display("FAIL early_capture a=%h stage=%b want 0000/00001", alu_a, stage);
                end
            end
            if (k == 7) begin
                total++;
                if (alu_a !== 16'hAAAA || stage !== 5'b00010) begin
                    bad++; $display("FAIL capture_latency a=%h stage=%b want aaaa/00010", alu_a, stage);
                end
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL model_hold got=%h want=%h", dut_vec, exp_vec());
            end
        end
        total++;
        if (stage !== 5'b00010) begin
            bad++; $display("FAIL single_advance stage=%b want 00010", stage);
        end
        btn_next = 1'b0;
        cyc(DC + 4);
    endtask

    task automatic test_clear();
        int en;
        do_press(1'b1, 1'b0, 16'h5555, 12, en);
        total++;
        if (stage !== 5'b00100 || alu_b !== 16'h5555 || alu_a !== 16'hAAAA) begin
            bad++; $display("FAIL load_b stage=%b a=%h b=%h want 00100/aaaa/5555", stage, alu_a, alu_b);
        end
        do_press(1'b0, 1'b1, 16'hFFFF, 12, en);
        total++;
        if (dut_vec !== RST_VEC) begin
            bad++; $display("FAIL clear_in_op got=%h want=%h", dut_vec, RST_VEC);
        end
        do_press(1'b1, 1'b0, 16'h1111, 12, en);
        do_press(1'b1, 1'b0, 16'h2222, 12, en);
        total++;
        if (stage !== 5'b00100 || alu_b !== 16'h2222) begin
            bad++; $display("FAIL reload stage=%b b=%h want 00100/2222", stage, alu_b);
        end
        do_press(1'b1, 1'b1, 16'h000F, 12, en);
        total++;
        if (dut_vec !== RST_VEC || en !== 0) begin
            bad++; $display("FAIL clear_wins got=%h en=%0d want=%h en=0", dut_vec, en, RST_VEC);
        end
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL model_clear got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_full_sequence();
        int en;
        do_press(1'b1, 1'b0, 16'h1234, 12, en);
        do_press(1'b1, 1'b0, 16'h00FF, 12, en);
        total++;
        if (en !== 0) begin
            bad++; $display("FAIL early_enable count=%0d want 0", en);
        end
        do_press(1'b1, 1'b0, 16'h0003, 30, en);
        total++;
        if (en !== 1) begin
            bad++; $display("FAIL enable_pulse count=%0d want 1", en);
        end
        total++;
        if (stage !== 5'b10000 || result_ready !== 1'b1) begin
            bad++; $display("FAIL done_state stage=%b ready=%b want 10000/1", stage, result_ready);
        end
        total++;
        if (alu_a !== 16'h1234 || alu_b !== 16'h00FF || alu_op !== 4'h3) begin
            bad++; $display("FAIL operands a=%h b=%h op=%h want 1234/00ff/3", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_done_wrap();
        int en;
        do_press(1'b1, 1'b0, 16'hBEEF, 12, en);
        total++;
        if (dut_vec !== {16'h1234, 16'h00FF, 4'h3, 1'b0, 1'b0, 5'b00001}) begin
            bad++; $display("FAIL done_wrap got=%h want=%h", dut_vec,
                            {16'h1234, 16'h00FF, 4'h3, 1'b0, 1'b0, 5'b00001});
        end
    endtask

    task automatic test_reset_mid_debounce();
        sw = 16'h0C0C;
        cyc(3);
        btn_next = 1'b1;
        cyc(4);
        reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec !== RST_VEC) begin
            bad++; $display("FAIL async_reset got=%h want=%h", dut_vec, RST_VEC);
        end
        cyc(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 7) begin
                total++;
                if (stage !== 5'b00001 || alu_a !== 16'h0000) begin
                    bad++; $display("FAIL post_reset_early k=%0d stage=%b a=%h", k, stage, alu_a);
                end
            end else begin
                total++;
                if (stage !== 5'b00010 || alu_a !== 16'h0C0C) begin
                    bad++; $display("FAIL post_reset_press k=%0d stage=%b a=%h want 00010/0c0c", k, stage, alu_a);
                end
            end
        end
        btn_next = 1'b0;
        cyc(DC + 4);
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random k=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
            if (hold == 0) begin
                btn_next  = 1'($urandom_range(0, 1));
                btn_clear = ($urandom_range(0, 7) == 0);
                sw        = 16'($urandom);
                hold      = $urandom_range(1, 12);
            end else begin
                hold--;
            end
        end
        btn_next = 1'b0; btn_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
        test_reset();
        test_glitch_capture();
        test_clear();
        test_full_sequence();
        test_done_wrap();
        test_reset_mid_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
